// File: rtl/spi_sd_master.sv
// SPI master for SD cards: SPI mode 0, MSB first, programmable SCK half-period,
// and dummy 0xFF transfers with chip select held high for power-up clocking.
module spi_sd_master #(
  parameter logic [7:0] DIV_INIT = 8'd34
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] div,
  input  logic       div_wr,
  input  logic       cs_en,
  input  logic [7:0] tx_data,
  input  logic       start,
  input  logic       dummy,
  output logic       ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] div_reg;
  logic [7:0] div_reg_next;
  logic [7:0] div_lat;
  logic [7:0] div_lat_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [7:0] tx_sh;
  logic [7:0] tx_sh_next;
  logic [7:0] rx_sh;
  logic [7:0] rx_sh_next;
  logic [7:0] rx_data_q;
  logic [7:0] rx_data_next;
  logic [3:0] bit_cnt;
  logic [3:0] bit_cnt_next;
  logic       sck_q;
  logic       sck_next;
  logic       mosi_q;
  logic       mosi_next;
  logic       cs_n_q;
  logic       cs_n_next;

  // Register every piece of state; reset forces the idle bus levels and aborts any transfer.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      div_reg   <= DIV_INIT;
      div_lat   <= DIV_INIT;
      cnt       <= 8'd0;
      tx_sh     <= 8'hFF;
      rx_sh     <= 8'd0;
      rx_data_q <= 8'd0;
      bit_cnt   <= 4'd0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b1;
      cs_n_q    <= 1'b1;
    end else begin
      state     <= state_next;
      div_reg   <= div_reg_next;
      div_lat   <= div_lat_next;
      cnt       <= cnt_next;
      tx_sh     <= tx_sh_next;
      rx_sh     <= rx_sh_next;
      rx_data_q <= rx_data_next;
      bit_cnt   <= bit_cnt_next;
      sck_q     <= sck_next;
      mosi_q    <= mosi_next;
      cs_n_q    <= cs_n_next;
    end
  end

  // Next-state and datapath: LOW/HIGH each last (latched divider + 1) cycles; sample on rise, shift on fall.
  always_comb begin
    state_next   = state;
    div_reg_next = div_wr ? div : div_reg;
    div_lat_next = div_lat;
    cnt_next     = cnt;
    tx_sh_next   = tx_sh;
    rx_sh_next   = rx_sh;
    rx_data_next = rx_data_q;
    bit_cnt_next = bit_cnt;
    sck_next     = sck_q;
    mosi_next    = mosi_q;
    cs_n_next    = cs_n_q;
    case (state)
      IDLE: begin
        sck_next  = 1'b0;
        mosi_next = 1'b1;
        cs_n_next = ~cs_en;
        if (start) begin
          div_lat_next = div_wr ? div : div_reg;
          cnt_next     = div_wr ? div : div_reg;
          tx_sh_next   = dummy ? 8'hFF : tx_data;
          mosi_next    = dummy ? 1'b1 : tx_data[7];
          cs_n_next    = dummy | ~cs_en;
          bit_cnt_next = 4'd0;
          state_next   = LOW;
        end
      end
      LOW: begin
        if (cnt == 8'd0) begin
          sck_next     = 1'b1;
          rx_sh_next   = {rx_sh[6:0], miso};
          cnt_next     = div_lat;
          bit_cnt_next = bit_cnt + 4'd1;
          state_next   = HIGH;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      HIGH: begin
        if (cnt == 8'd0) begin
          sck_next = 1'b0;
          if (bit_cnt < 4'd8) begin
            tx_sh_next = {tx_sh[6:0], 1'b0};
            mosi_next  = tx_sh[6];
            cnt_next   = div_lat;
            state_next = LOW;
          end else begin
            mosi_next    = 1'b1;
            rx_data_next = rx_sh;
            state_next   = DONE;
          end
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      DONE: begin
        mosi_next  = 1'b1;
        cs_n_next  = ~cs_en;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready    = (state == IDLE);
  assign rx_valid = (state == DONE);
  assign rx_data  = rx_data_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_sd_master.sv
// Bench for spi_sd_master: directed SD scenarios plus randomized transfers,
// checked by a scoreboard against a transfer-level timing and data model.
module tb_spi_sd_master;

  localparam logic [7:0] DIV_INIT = 8'd34;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [7:0] div;
  logic       div_wr;
  logic       cs_en;
  logic [7:0] tx_data;
  logic       start;
  logic       dummy;
  logic       ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  logic [1:0] miso_mode;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         t0;
    int         half;
    logic       csn;
  } xfer_t;

  xfer_t      sb[$];
  int         cycle = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         model_div = 34;
  int         free_at = 0;
  logic [7:0] model_last_rx = 8'd0;
  int         rises = 0;
  int         falls = 0;
  int         idle_chk = -1;
  logic       idle_cs = 1'b1;
  logic       sck_prev = 1'b0;
  xfer_t      cur;

  spi_sd_master #(.DIV_INIT(DIV_INIT)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .div     (div),
    .div_wr  (div_wr),
    .cs_en   (cs_en),
    .tx_data (tx_data),
    .start   (start),
    .dummy   (dummy),
    .ready   (ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  // Card model: echo mosi, echo it inverted, or hold miso low.
  assign miso = (miso_mode == 2'd2) ? 1'b0 : (mosi ^ (miso_mode == 2'd1));

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyReset(input int n);
    reset = 1'b1;
    repeat (n) nextCycle();
    reset = 1'b0;
    model_div = int'(DIV_INIT);
    free_at = cycle;
    checkOutput("rst_sck", sck, 1'b0);
    checkOutput("rst_mosi", mosi, 1'b1);
    checkOutput("rst_cs_n", cs_n, 1'b1);
    checkOutput("rst_ready", ready, 1'b1);
    checkOutput("rst_rx_valid", rx_valid, 1'b0);
    checkOutput("rst_rx_data", rx_data, 8'h00);
  endtask

  // Issue one transfer once the model says the master is idle; push its expected outcome.
  task automatic applyStimulus(input logic [7:0] tx, input logic dm, input logic wr,
                               input logic [7:0] wdiv, input logic [1:0] mode,
                               input logic ce, input int gap, output int t0);
    xfer_t item;
    int    half;
    while (cycle < free_at) nextCycle();
    repeat (gap) nextCycle();
    checkOutput("ready_before_start", ready, 1'b1);
    tx_data   = tx;
    dummy     = dm;
    div_wr    = wr;
    div       = wdiv;
    miso_mode = mode;
    cs_en     = ce;
    start     = 1'b1;
    if (wr) model_div = int'(wdiv);
    half = model_div + 1;
    nextCycle();
    t0     = cycle;
    start  = 1'b0;
    div_wr = 1'b0;
    dummy  = 1'b0;
    item.tx   = dm ? 8'hFF : tx;
    item.rx   = (mode == 2'd2) ? 8'h00 : ((mode == 2'd1) ? ~item.tx : item.tx);
    item.t0   = t0;
    item.half = half;
    item.csn  = dm ? 1'b1 : ~ce;
    sb.push_back(item);
    free_at = t0 + 16 * half + 1;
  endtask

  // Disturbances while busy: an ignored start, a divider write, a chip-select change.
  task automatic midActions(input int t0, input logic inject, input logic wr,
                            input logic [7:0] wdiv, input logic flip_cs);
    while (cycle < t0 + 2) nextCycle();
    if (inject) begin
      checkOutput("ready_while_busy", ready, 1'b0);
      tx_data = 8'($urandom);
      start   = 1'b1;
      nextCycle();
      start = 1'b0;
    end
    if (wr) begin
      div    = wdiv;
      div_wr = 1'b1;
      model_div = int'(wdiv);
      nextCycle();
      div_wr = 1'b0;
    end
    if (flip_cs) cs_en = ~cs_en;
  endtask

  // Scoreboard monitor: checks bus timing and data for the transfer at the queue head.
  always @(negedge clk_sys) begin
    if (reset) begin
      sb.delete();
      model_last_rx = 8'h00;
      rises = 0;
      falls = 0;
      idle_chk = -1;
    end else begin
      if (sb.size() > 0) begin
        cur = sb[0];
        if (cycle >= cur.t0 && cycle <= cur.t0 + 16 * cur.half) begin
          checkOutput("cs_n_xfer", cs_n, cur.csn);
          checkOutput("ready_xfer", ready, 1'b0);
        end
        if (cycle >= cur.t0 && cycle < cur.t0 + 16 * cur.half)
          checkOutput("rx_hold_xfer", rx_data, model_last_rx);
        if (sck && !sck_prev) begin
          rises++;
          checkOutput("sck_rise_time", cycle, cur.t0 + (2 * rises - 1) * cur.half);
          if (rises <= 8) checkOutput("mosi_bit", mosi, cur.tx[8-rises]);
          else checkOutput("sck_rise_count", rises, 8);
        end
        if (!sck && sck_prev) begin
          falls++;
          checkOutput("sck_fall_time", cycle, cur.t0 + 2 * falls * cur.half);
        end
      end else begin
        checkOutput("sck_idle", sck, 1'b0);
        checkOutput("rx_hold_idle", rx_data, model_last_rx);
      end
      if (rx_valid) begin
        if (sb.size() == 0) begin
          checkOutput("rx_valid_unexpected", rx_valid, 1'b0);
        end else begin
          cur = sb.pop_front();
          checkOutput("rx_data", rx_data, cur.rx);
          checkOutput("rx_valid_time", cycle, cur.t0 + 16 * cur.half);
          checkOutput("mosi_done", mosi, 1'b1);
          checkOutput("sck_pulses", rises, 8);
          model_last_rx = cur.rx;
          idle_chk = cycle + 1;
          idle_cs = ~cs_en;
          rises = 0;
          falls = 0;
        end
      end
      if (cycle == idle_chk) checkOutput("cs_n_idle", cs_n, idle_cs);
    end
    sck_prev = sck;
  end

  initial begin
    int         t0;
    logic [7:0] tx;
    logic       dm;
    logic       wr;
    logic [7:0] wdiv;
    logic [1:0] mode;
    logic       ce;
    reset     = 1'b1;
    div       = 8'd0;
    div_wr    = 1'b0;
    cs_en     = 1'b0;
    tx_data   = 8'h00;
    start     = 1'b0;
    dummy     = 1'b0;
    miso_mode = 2'd0;
    nextCycle();
    applyReset(3);
    $display("[TB] reset state checked");

    // Default divider after reset, card holds miso low.
    applyStimulus(8'h40, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1, 1, t0);
    // Loopback at full speed with the divider written alongside start.
    applyStimulus(8'hA5, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1, 2, t0);
    // Dummy byte with card selected: cs_n stays high until idle.
    applyStimulus(8'h00, 1'b1, 1'b1, 8'd1, 2'd0, 1'b1, 1, t0);
    // Back-to-back bytes with a start injected mid-transfer.
    applyStimulus(8'h12, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1, 0, t0);
    midActions(t0, 1'b1, 1'b0, 8'd0, 1'b0);
    applyStimulus(8'h34, 1'b0, 1'b0, 8'd0, 2'd1, 1'b1, 0, t0);
    // Divider rewritten mid-transfer only affects the next byte.
    applyStimulus(8'h5C, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1, 0, t0);
    midActions(t0, 1'b0, 1'b1, 8'd2, 1'b1);
    applyStimulus(8'hC3, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1, 0, t0);
    // Abort a slow transfer with reset, then confirm the divider returned to its default.
    applyStimulus(8'h99, 1'b0, 1'b1, 8'd3, 2'd0, 1'b1, 1, t0);
    while (cycle < t0 + 19) nextCycle();
    applyReset(1);
    applyStimulus(8'h81, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1, t0);
    $display("[TB] directed scenarios issued");

    for (int i = 0; i < 40; i++) begin
      tx   = 8'($urandom);
      dm   = ($urandom_range(0, 4) == 0);
      wr   = (i == 0) || ($urandom_range(0, 2) == 0);
      wdiv = 8'($urandom_range(0, 3));
      mode = 2'($urandom_range(0, 2));
      ce   = 1'($urandom);
      applyStimulus(tx, dm, wr, wdiv, mode, ce, $urandom_range(0, 3), t0);
      midActions(t0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 8'($urandom_range(0, 3)), 1'($urandom));
    end

    while (cycle < free_at + 3) nextCycle();
    checkOutput("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_sd_master.md
SPI_SD_MASTER -- requirements
Module: spi_sd_master

Interface
REQ-001 Parameter DIV_INIT, default 8'd34, is the SCK half-period divider loaded at reset (28 MHz / (2*35) = 400 kHz for SD init).
REQ-002 clk_sys  in  1  system clock; all logic is on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 div  in  8  runtime half-period divider; half-period = div+1 clk_sys cycles.
REQ-005 div_wr  in  1  loads div into the active divider register when high.
REQ-006 cs_en  in  1  requested chip-select state; 1 = card selected.
REQ-007 tx_data  in  8  byte to shift out, MSB first.
REQ-008 start  in  1  single-cycle transfer request.
REQ-009 dummy  in  1  qualifies start: sends 0xFF with cs_n forced high (SD power-up clocks).
REQ-010 ready  out  1  high when idle and able to accept start.
REQ-011 rx_data  out  8  last byte received.
REQ-012 rx_valid  out  1  one-cycle pulse when rx_data is updated.
REQ-013 sck  out  1  SPI clock, mode 0.
REQ-014 mosi  out  1  SPI data out.
REQ-015 miso  in  1  SPI data in.
REQ-016 cs_n  out  1  SPI chip select, active low.

Function
REQ-017 The block SHALL implement SPI mode 0: sck idles low, miso is sampled on the sck rise, mosi changes on the sck fall, MSB first.
REQ-018 The FSM SHALL have states IDLE, LOW, HIGH and DONE, with ready high only in IDLE.
REQ-019 In IDLE, start SHALL latch tx_data (or 0xFF if dummy), the divider and dummy; it SHALL drive mosi to bit 7, load the half-period counter with the divider, and enter LOW.
REQ-020 LOW SHALL hold for divider+1 cycles, then set sck high, shift miso into the receive register, reload the counter, and enter HIGH.
REQ-021 HIGH SHALL hold for divider+1 cycles, then set sck low. If the bit count is below 8, it SHALL present the next bit on mosi and enter LOW; otherwise it SHALL enter DONE.
REQ-022 DONE SHALL last exactly one cycle, with rx_valid=1, rx_data=received byte and mosi=1, then return to IDLE.
REQ-023 Latency from the start-sampling edge T0: the first sck rise SHALL occur at T0+(div+1), the 8th sck fall at T0+16(div+1), rx_valid SHALL be high in cycle T0+16(div+1), and ready SHALL be high from T0+16(div+1)+1.
REQ-024 A start asserted while ready=0 SHALL be ignored and not queued.
REQ-025 A start asserted in the first ready cycle SHALL begin a new transfer with no gap cycles.
REQ-026 div_wr SHALL take effect immediately on the divider register; the transfer in progress SHALL keep its latched divider.
REQ-027 If div_wr and start occur in the same cycle, the transfer SHALL use the newly written div.
REQ-028 cs_n SHALL be updated to ~cs_en only in IDLE; cs_en changes during a transfer SHALL be applied on return to IDLE.
REQ-029 During a dummy transfer cs_n SHALL be 1 regardless of cs_en, and the cs_en state SHALL be restored in IDLE.
REQ-030 With div=0, sck SHALL toggle every clk_sys cycle (clk_sys/2).
REQ-031 rx_data SHALL hold its value until the next DONE.
REQ-032 mosi SHALL be 1 whenever the FSM is not in LOW or HIGH.

Reset
REQ-033 On reset, outputs SHALL be: sck=0, mosi=1, cs_n=1, ready=1, rx_valid=0, rx_data=0x00; the FSM SHALL be IDLE and the divider SHALL be DIV_INIT.
REQ-034 A reset asserted mid-transfer SHALL abort the transfer within one cycle, with no rx_valid pulse and the same output values as REQ-033.

Verification
REQ-035 div=0, cs_en=1, miso looped to mosi, start with tx_data=0xA5 -> cs_n=0, 8 sck pulses, rx_valid at T0+16, rx_data=0xA5.
REQ-036 Reset default DIV_INIT=34, start with tx_data=0x40, miso=0 -> sck half-period of 35 cycles, rx_valid at T0+560, rx_data=0x00, mosi bits 0,1,0,0,0,0,0,0.
REQ-037 div=1, start with dummy=1 and cs_en=1 -> cs_n=1 for the whole transfer, mosi=1 throughout, cs_n=0 in the following IDLE cycle.
REQ-038 div=0, back-to-back starts with 0x12 then 0x34, and a second start injected mid-transfer -> the mid-transfer start is ignored, the second byte begins the cycle after rx_valid, and 16 sck pulses occur in total.
REQ-039 div=3, start, reset asserted at T0+20 -> next cycle sck=0, mosi=1, cs_n=1, ready=1, no rx_valid pulse, divider=DIV_INIT.
REQ-040 div_wr with div=2 during a div=0 transfer -> the current byte completes at T0+16, and the next byte has a half-period of 3 cycles.
